// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with a baud divider and a small input FIFO.
// Each frame is a start bit, DBIT data bits sent LSB first, an optional parity bit and
// a stop period of SB_TICK ticks. The divisor and parity mode are captured when a word
// leaves the FIFO, so they stay fixed for the whole of that frame.
// Ports:
//   i_clock, i_reset        clock, synchronous active-high reset
//   i_divisor               a baud tick occurs every i_divisor+1 clocks
//   i_parity_mode           00 none, 01 even, 10 odd, 11 mark
//   i_data, i_valid/o_ready word push handshake into the FIFO
//   o_tx                    registered serial line, idle high
//   o_busy                  a frame is in progress (state is not IDLE)
//   o_tx_done               one-clock pulse when a frame ends
//   o_fifo_count            current FIFO occupancy
module uart_tx_param #(
  parameter int DBIT       = 8,
  parameter int OVERSAMPLE = 16,
  parameter int SB_TICK    = 16,
  parameter int DIV_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int NB_STATE   = 3
) (
  input  logic                          i_clock,
  input  logic                          i_reset,
  input  logic [DIV_WIDTH-1:0]          i_divisor,
  input  logic [1:0]                    i_parity_mode,
  input  logic [DBIT-1:0]               i_data,
  input  logic                          i_valid,
  output logic                          o_ready,
  output logic                          o_tx,
  output logic                          o_busy,
  output logic                          o_tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int PW   = $clog2(FIFO_DEPTH);
  localparam int CNTW = PW + 1;
  localparam int TMAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TW   = $clog2(TMAX) + 1;
  localparam int BW   = $clog2(DBIT) + 1;

  localparam logic [TW-1:0]   OS_LAST  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0]   SB_LAST  = TW'(SB_TICK - 1);
  localparam logic [BW-1:0]   BIT_LAST = BW'(DBIT - 1);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(FIFO_DEPTH);

  typedef enum logic [NB_STATE-1:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                state_q, state_nx;
  logic [TW-1:0]         s_q, s_nx;          // ticks within the current bit
  logic [BW-1:0]         bit_q, bit_nx;      // data bits already sent
  logic [DBIT-1:0]       shreg_q, shreg_nx;
  logic                  par_q, par_nx;      // parity bit value for this frame
  logic                  par_en_q, par_en_nx;
  logic [DIV_WIDTH-1:0]  div_q, div_nx;
  logic [DIV_WIDTH-1:0]  baud_q, baud_nx;
  logic                  tx_q, tx_nx;
  logic                  done_q, done_nx;

  logic [DBIT-1:0]       mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CNTW-1:0]       count_q, cnt_nx;
  logic                  ready_q;

  logic push, pop, tick;
  logic [DBIT-1:0] head;

  assign push = i_valid && ready_q;
  assign pop  = (state_q == IDLE) && (count_q != '0);
  assign tick = (baud_q == div_q);
  assign head = mem[rd_ptr_q];

  // FIFO occupancy; push and pop on the same edge cancel out
  always_comb begin
    cnt_nx = count_q;
    case ({push, pop})
      2'b10:   cnt_nx = count_q + CNTW'(1);
      2'b01:   cnt_nx = count_q - CNTW'(1);
      default: cnt_nx = count_q;
    endcase
  end

  // Baud counter restarts on the pop edge so the start bit gets a full period
  always_comb begin
    baud_nx = baud_q + DIV_WIDTH'(1);
    if (pop || tick) baud_nx = '0;
  end

  always_comb begin
    state_nx  = state_q;
    s_nx      = s_q;
    bit_nx    = bit_q;
    shreg_nx  = shreg_q;
    par_nx    = par_q;
    par_en_nx = par_en_q;
    div_nx    = div_q;
    done_nx   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pop) begin
          state_nx  = START;
          s_nx      = '0;
          bit_nx    = '0;
          shreg_nx  = head;
          div_nx    = i_divisor;
          par_en_nx = (i_parity_mode != 2'b00);
          case (i_parity_mode)
            2'b01:   par_nx = ^head;
            2'b10:   par_nx = ~^head;
            default: par_nx = 1'b1;
          endcase
        end
      end
      START: begin
        if (tick) begin
          if (s_q == OS_LAST) begin
            state_nx = DATA;
            s_nx     = '0;
          end else s_nx = s_q + TW'(1);
        end
      end
      DATA: begin
        if (tick) begin
          if (s_q == OS_LAST) begin
            s_nx     = '0;
            shreg_nx = shreg_q >> 1;
            if (bit_q == BIT_LAST) begin
              bit_nx   = '0;
              state_nx = par_en_q ? PARITY : STOP;
            end else bit_nx = bit_q + BW'(1);
          end else s_nx = s_q + TW'(1);
        end
      end
      PARITY: begin
        if (tick) begin
          if (s_q == OS_LAST) begin
            state_nx = STOP;
            s_nx     = '0;
          end else s_nx = s_q + TW'(1);
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == SB_LAST) begin
            state_nx = IDLE;
            s_nx     = '0;
            done_nx  = 1'b1;
          end else s_nx = s_q + TW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Line level is derived from the next state so o_tx can come straight from a flop
  always_comb begin
    tx_nx = 1'b1;
    case (state_nx)
      START:   tx_nx = 1'b0;
      DATA:    tx_nx = shreg_nx[0];
      PARITY:  tx_nx = par_nx;
      default: tx_nx = 1'b1;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q  <= IDLE;
      s_q      <= '0;
      bit_q    <= '0;
      shreg_q  <= '0;
      par_q    <= 1'b0;
      par_en_q <= 1'b0;
      div_q    <= '0;
      baud_q   <= '0;
      tx_q     <= 1'b1;
      done_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
    end else begin
      state_q  <= state_nx;
      s_q      <= s_nx;
      bit_q    <= bit_nx;
      shreg_q  <= shreg_nx;
      par_q    <= par_nx;
      par_en_q <= par_en_nx;
      div_q    <= div_nx;
      baud_q   <= baud_nx;
      tx_q     <= tx_nx;
      done_q   <= done_nx;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q  <= cnt_nx;
      ready_q  <= (cnt_nx != CNT_FULL);
    end
  end

  // Storage needs no reset: the pointers define what is valid
  always_ff @(posedge i_clock) begin
    if (!i_reset && push) mem[wr_ptr_q] <= i_data;
  end

  assign o_ready      = ready_q;
  assign o_tx         = tx_q;
  assign o_busy       = (state_q != IDLE);
  assign o_tx_done    = done_q;
  assign o_fifo_count = count_q;

endmodule
